// File: rtl/ecc32_pkg.sv
// Shared definitions for the 32-bit SEC code: widths, g-index map and the
// check-bit function that doubles as the golden model for the corrector bench.
package ecc32_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam logic [5:0] INJ_NONE = 6'd40;

  // check bit k folds in g[G_MAP[k]]
  localparam int G_MAP [CHK_W] = '{4, 5, 6, 7, 0, 1, 2, 3};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              inj_en;
    logic [5:0]        inj_pos;
    logic [CHK_W-1:0]  f;
    logic [CHK_W-1:0]  xe;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
    logic              flipped;
  } s2_t;

  function automatic logic [CHK_W-1:0] ecc32_f(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] f;
    for (int j = 0; j < CHK_W; j++) f[j] = ^d[4*j +: 4];
    return f;
  endfunction

  function automatic logic [CHK_W-1:0] ecc32_xe(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] xe;
    for (int k = 0; k < 4; k++) xe[k] = d[k] ^ d[k+4] ^ d[k+8] ^ d[k+12];
    for (int k = 4; k < 8; k++) xe[k] = d[k+12] ^ d[k+16] ^ d[k+20] ^ d[k+24];
    return xe;
  endfunction

  function automatic logic [CHK_W-1:0] ecc32_check_fx(input logic [CHK_W-1:0] f,
                                                      input logic [CHK_W-1:0] xe);
    logic [CHK_W-1:0] g;
    logic [CHK_W-1:0] c;
    g[0] = f[0] ^ f[1];
    g[1] = f[2] ^ f[3];
    g[2] = f[0] ^ f[2];
    g[3] = f[1] ^ f[3];
    g[4] = f[4] ^ f[5];
    g[5] = f[6] ^ f[7];
    g[6] = f[4] ^ f[6];
    g[7] = f[5] ^ f[7];
    for (int k = 0; k < CHK_W; k++) c[k] = xe[k] ^ g[G_MAP[k]];
    return c;
  endfunction

  function automatic logic [CHK_W-1:0] ecc32_check(input logic [DATA_W-1:0] d);
    return ecc32_check_fx(ecc32_f(d), ecc32_xe(d));
  endfunction

endpackage

// File: rtl/ecc32_pipe_reg.sv
// Valid/ready register slice; accepts whenever empty or draining, so a full
// pipeline of these sustains one word per cycle.
module ecc32_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid | dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/ecc32_check_gen_pipe.sv
// Two-stage check-bit generator for the 32-bit SEC code with optional
// single-bit error injection and saturating delivery statistics.
module ecc32_check_gen_pipe
  import ecc32_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic              id_clk,
  input  logic              id_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic [5:0]        inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic              out_r,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  inj_cnt
);

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic v1, v2, s2_ready;
  logic [DATA_W+CHK_W-1:0] word, mask;
  logic hs;

  always_comb begin
    s1_d.data    = in_data;
    s1_d.inj_en  = inj_en;
    s1_d.inj_pos = inj_pos;
    s1_d.f       = ecc32_f(in_data);
    s1_d.xe      = ecc32_xe(in_data);
  end

  ecc32_pipe_reg #(.W($bits(s1_t))) u_stage1 (
    .clk      (id_clk),
    .rst      (id_rst),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  (s1_d),
    .dn_valid (v1),
    .dn_ready (s2_ready),
    .dn_data  (s1_q)
  );

  // check bits come from the clean data; the flip lands on the outgoing word only
  always_comb begin
    s2_d.flipped = INJ_EN && s1_q.inj_en && (s1_q.inj_pos < INJ_NONE);
    mask = '0;
    if (s2_d.flipped) mask = (DATA_W+CHK_W)'(1) << s1_q.inj_pos;
    word = {ecc32_check_fx(s1_q.f, s1_q.xe), s1_q.data} ^ mask;
    s2_d.data  = word[DATA_W-1:0];
    s2_d.check = word[DATA_W +: CHK_W];
  end

  ecc32_pipe_reg #(.W($bits(s2_t))) u_stage2 (
    .clk      (id_clk),
    .rst      (id_rst),
    .up_valid (v1),
    .up_ready (s2_ready),
    .up_data  (s2_d),
    .dn_valid (v2),
    .dn_ready (out_ready),
    .dn_data  (s2_q)
  );

  assign out_valid = v2;
  assign out_r     = v2;
  assign out_data  = s2_q.data;
  assign out_check = s2_q.check;
  assign hs        = v2 & out_ready;

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else if (hs) begin
      if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
      if (s2_q.flipped && (inj_cnt != '1)) inj_cnt <= inj_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc32_check_gen_pipe.sv
// Self-checking bench for ecc32_check_gen_pipe: vector table, stall, reset
// and saturation sequences, with a scoreboard queue compared at the output.
module tb_ecc32_check_gen_pipe;

  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             id_clk, id_rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_data;
  logic             inj_en;
  logic [5:0]       inj_pos;
  logic             out_valid, out_ready, out_r;
  logic [31:0]      out_data;
  logic [7:0]       out_check;
  logic [CNT_W-1:0] word_cnt, inj_cnt;

  ecc32_check_gen_pipe #(.CNT_W(CNT_W), .INJ_EN(1'b1)) dut (
    .id_clk    (id_clk),
    .id_rst    (id_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .out_r     (out_r),
    .word_cnt  (word_cnt),
    .inj_cnt   (inj_cnt)
  );

  initial id_clk = 1'b0;
  always #5 id_clk = ~id_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  check;
    logic        flip;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [5:0]  pos;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0;
  int   exp_words = 0, exp_inj = 0;
  bit   saw_not_ready = 0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  function automatic logic [7:0] model_check(input logic [31:0] d);
    logic [7:0] f, g, xe, c;
    for (int j = 0; j < 8; j++) f[j] = d[4*j] ^ d[4*j+1] ^ d[4*j+2] ^ d[4*j+3];
    g = {f[5]^f[7], f[4]^f[6], f[6]^f[7], f[4]^f[5],
         f[1]^f[3], f[0]^f[2], f[2]^f[3], f[0]^f[1]};
    for (int k = 0; k < 4; k++) xe[k] = d[k] ^ d[k+4] ^ d[k+8] ^ d[k+12];
    for (int k = 4; k < 8; k++) xe[k] = d[k+12] ^ d[k+16] ^ d[k+20] ^ d[k+24];
    for (int k = 0; k < 8; k++) c[k] = xe[k] ^ g[(k + 4) % 8];
    return c;
  endfunction

  function automatic exp_t model_exp(input logic [31:0] d, input logic en, input logic [5:0] pos);
    exp_t e;
    logic [39:0] w;
    w = {model_check(d), d};
    e.flip = en && (pos <= 6'd39);
    if (e.flip) w[pos] = ~w[pos];
    e.data  = w[31:0];
    e.check = w[39:32];
    return e;
  endfunction

  // output monitor: scoreboard compare, stall stability, counter model
  initial begin
    logic [31:0] pd;
    logic [7:0]  pc;
    logic        stalled;
    exp_t        e;
    stalled = 1'b0;
    pd = '0;
    pc = '0;
    forever begin
      @(negedge id_clk);
      if (id_rst) begin
        sb.delete();
        exp_words = 0;
        exp_inj = 0;
        saw_not_ready = 0;
        stalled = 1'b0;
      end else begin
        if (!in_ready) saw_not_ready = 1;
        if (stalled) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, pd);
          chk("stall_check", out_check, pc);
        end
        chk("out_r", out_r, out_valid ? 1 : 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL extra_word: got data 0x%0h with no word outstanding", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_check", out_check, e.check);
            if (exp_words < CMAX) exp_words++;
            if (e.flip && exp_inj < CMAX) exp_inj++;
          end
        end
        stalled = out_valid && !out_ready;
        pd = out_data;
        pc = out_check;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic en, input logic [5:0] pos, input exp_t e);
    int waitc = 0;
    @(negedge id_clk);
    in_valid = 1'b1;
    in_data  = d;
    inj_en   = en;
    inj_pos  = pos;
    while (!in_ready && waitc < 200) begin
      @(negedge id_clk);
      waitc++;
    end
    if (waitc >= 200) begin
      n_total++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required high", waitc);
    end else begin
      @(posedge id_clk);
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() > 0 && c < 200) begin
      @(negedge id_clk);
      c++;
    end
    if (c >= 200) begin
      n_total++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
    @(posedge id_clk);
    @(negedge id_clk);
  endtask

  task automatic do_reset();
    @(negedge id_clk);
    id_rst = 1'b1;
    in_valid = 1'b0;
    @(posedge id_clk);
    @(negedge id_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_check", out_check, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_inj_cnt", inj_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge id_clk);
    #1 id_rst = 1'b0;
  endtask

  task automatic latency_word(input logic [31:0] d);
    send(d, 1'b0, 6'd0, model_exp(d, 1'b0, 6'd0));
    @(negedge id_clk);
    chk("lat_edge1_valid", out_valid, 0);
    @(negedge id_clk);
    chk("lat_edge2_valid", out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0000_0001, 1'b0, 6'd40, '{32'h0000_0001, 8'h51, 1'b0}};
    vecs[1]  = '{32'h8000_0000, 1'b0, 6'd0,  '{32'h8000_0000, 8'h8A, 1'b0}};
    vecs[2]  = '{32'hFFFF_FFFF, 1'b0, 6'd0,  '{32'hFFFF_FFFF, 8'h00, 1'b0}};
    vecs[3]  = '{32'h0000_0001, 1'b1, 6'd5,  '{32'h0000_0021, 8'h51, 1'b1}};
    vecs[4]  = '{32'h0000_0001, 1'b1, 6'd32, '{32'h0000_0001, 8'h50, 1'b1}};
    vecs[5]  = '{32'h0000_0001, 1'b1, 6'd45, '{32'h0000_0001, 8'h51, 1'b0}};
    vecs[6]  = '{32'h0000_0001, 1'b1, 6'd39, '{32'h0000_0001, 8'hD1, 1'b1}};
    vecs[7]  = '{32'h0000_0001, 1'b1, 6'd31, '{32'h8000_0001, 8'h51, 1'b1}};
    vecs[8]  = '{32'h0000_0001, 1'b1, 6'd40, '{32'h0000_0001, 8'h51, 1'b0}};
    vecs[9]  = '{32'h0000_0000, 1'b1, 6'd0,  '{32'h0000_0001, 8'h00, 1'b1}};
    vecs[10] = '{32'h0000_0001, 1'b0, 6'd5,  '{32'h0000_0001, 8'h51, 1'b0}};

    id_rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    inj_en = 1'b0;
    inj_pos = '0;
    out_ready = 1'b1;
    do_reset();

    // first word after reset, zero data
    latency_word(32'h0000_0000);
    drain();
    chk("first_word_cnt", word_cnt, 1);
    chk("first_inj_cnt", inj_cnt, 0);

    // vector table, injection boundaries included
    for (int i = 0; i < 11; i++) send(vecs[i].data, vecs[i].en, vecs[i].pos, vecs[i].exp);
    drain();
    chk("table_word_cnt", word_cnt, 12);
    chk("table_inj_cnt", inj_cnt, 5);

    // 8 back-to-back words with the consumer stalled for four cycles
    do_reset();
    fork
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge id_clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge id_clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] d;
          d = 32'hA500_0000 + i * 32'h0101_0101;
          send(d, 1'b0, 6'd0, model_exp(d, 1'b0, 6'd0));
        end
      end
    join
    drain();
    chk("stall_in_ready_fell", saw_not_ready, 1);
    chk("stall_word_cnt", word_cnt, 8);

    // reset with both stages full, then a clean word
    out_ready = 1'b0;
    send(32'h1111_1111, 1'b1, 6'd3, model_exp(32'h1111_1111, 1'b1, 6'd3));
    send(32'h2222_2222, 1'b0, 6'd0, model_exp(32'h2222_2222, 1'b0, 6'd0));
    @(negedge id_clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    do_reset();
    out_ready = 1'b1;
    latency_word(32'h1234_5678);
    drain();
    chk("post_rst_word_cnt", word_cnt, 1);
    chk("post_rst_inj_cnt", inj_cnt, 0);

    // random traffic with random back-pressure, driving the counters into saturation
    do_reset();
    fork
      begin
        for (int c = 0; c < 80; c++) begin
          @(posedge id_clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge id_clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 41; i++) begin
          logic [31:0] d;
          logic        en;
          logic [5:0]  pos;
          d   = $urandom;
          en  = (i < 36) ? 1'b1 : 1'($urandom_range(0, 1));
          pos = (i < 36) ? 6'($urandom_range(0, 39)) : 6'($urandom_range(0, 63));
          send(d, en, pos, model_exp(d, en, pos));
        end
      end
    join
    drain();
    chk("sat_word_cnt", word_cnt, CMAX);
    chk("sat_inj_cnt", inj_cnt, CMAX);
    send(32'hDEAD_BEEF, 1'b1, 6'd7, model_exp(32'hDEAD_BEEF, 1'b1, 6'd7));
    drain();
    chk("sat_hold_word_cnt", word_cnt, CMAX);
    chk("sat_hold_inj_cnt", inj_cnt, CMAX);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
